alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_pkg.sv | 43 ++++
 rtl/alu_arb_alu.sv | 44 ++++
 rtl/alu_arb.sv | 131 +++++++++++++
 tb/tb_alu_arb.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the ALU function field and the arbiter's output-register state.
// fn[5:4] selects the class; fn[3:0] is a boolean truth table or a shift selector.
package alu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned FN_W = 6;

  localparam logic [1:0] FN_CLS_ZERO  = 2'b00;
  localparam logic [1:0] FN_CLS_ARITH = 2'b01;
  localparam logic [1:0] FN_CLS_BOOL  = 2'b10;
  localparam logic [1:0] FN_CLS_SHIFT = 2'b11;

  localparam int unsigned FN_SUB_BIT = 0;

  // Boolean selectors are truth tables indexed by {src1_bit, src2_bit}
  localparam logic [3:0] BOOL_AND  = 4'b1000;
  localparam logic [3:0] BOOL_OR   = 4'b1110;
  localparam logic [3:0] BOOL_XOR  = 4'b0110;
  localparam logic [3:0] BOOL_NOR  = 4'b0001;
  localparam logic [3:0] BOOL_SRC1 = 4'b1100;
  localparam logic [3:0] BOOL_SRC2 = 4'b1010;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;
  localparam logic [1:0] SH_ROL = 2'b11;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  function automatic logic [XLEN-1:0] bool_op(input logic [3:0] tt,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    for (int i = 0; i < XLEN; i++) begin
      r[i] = tt[{a[i], b[i]}];
    end
    return r;
  endfunction

endpackage

// File: rtl/alu_arb_alu.sv
// Shared 32-bit combinational ALU: zero / add-sub / truth-table boolean / shift classes.
// Arithmetic wraps modulo 2^32 and no flags are produced.
import alu_pkg::*;

module alu_arb_alu (
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic [FN_W-1:0] i_fn,
  output logic [XLEN-1:0] o_result
);

  logic [4:0]      w_shamt;
  logic [XLEN-1:0] w_shift;

  // Shift unit; rotate uses a 6-bit complement so a zero amount yields src1 unchanged
  always_comb begin
    w_shamt = i_src2[4:0];
    case (i_fn[1:0])
      SH_SLL:  w_shift = i_src1 << w_shamt;
      SH_SRL:  w_shift = i_src1 >> w_shamt;
      SH_SRA:  w_shift = XLEN'($signed(i_src1) >>> w_shamt);
      SH_ROL:  w_shift = (i_src1 << w_shamt) | (i_src1 >> (6'd32 - {1'b0, w_shamt}));
      default: w_shift = '0;
    endcase
  end

  // Class decode
  always_comb begin
    case (i_fn[5:4])
      FN_CLS_ZERO:  o_result = '0;
      FN_CLS_ARITH: begin
        if (i_fn[FN_SUB_BIT]) begin
          o_result = i_src1 - i_src2;
        end else begin
          o_result = i_src1 + i_src2;
        end
      end
      FN_CLS_BOOL:  o_result = bool_op(i_fn[3:0], i_src1, i_src2);
      FN_CLS_SHIFT: o_result = w_shift;
      default:      o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// Two-requester arbiter in front of one shared ALU with a one-entry registered result slot.
// Define ALU_ARB_RR_EN for round-robin tie-breaking; otherwise requester 0 wins every tie.
import alu_pkg::*;

module alu_arb (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [XLEN-1:0] req0_src1,
  input  logic [XLEN-1:0] req0_src2,
  input  logic [FN_W-1:0] req0_fn,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [XLEN-1:0] req1_src1,
  input  logic [XLEN-1:0] req1_src2,
  input  logic [FN_W-1:0] req1_fn,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result
);

  out_state_e      r_state;
  logic            r_owner;
  logic            r_rsp0_valid;
  logic            r_rsp1_valid;
  logic [XLEN-1:0] r_result;

  logic            w_own_ready;
  logic            w_slot_ok;
  logic            w_accept;
  logic            w_gnt;
  logic [XLEN-1:0] w_src1;
  logic [XLEN-1:0] w_src2;
  logic [FN_W-1:0] w_fn;
  logic [XLEN-1:0] w_alu_result;

`ifdef ALU_ARB_RR_EN
  logic            r_prio;
`endif

  // Slot availability and grant selection; only the owner's rsp_ready can free the slot
  always_comb begin
    w_own_ready = r_owner ? rsp1_ready : rsp0_ready;
    w_slot_ok   = (r_state == OUT_EMPTY) || ((r_state == OUT_FULL) && w_own_ready);
    w_accept    = rst_n && w_slot_ok && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      w_gnt = r_prio;
`else
      w_gnt = 1'b0;
`endif
    end else if (req1_valid) begin
      w_gnt = 1'b1;
    end else begin
      w_gnt = 1'b0;
    end
  end

  assign req0_ready = w_accept && !w_gnt;
  assign req1_ready = w_accept && w_gnt;

  // Operand mux: only the granted requester drives the shared ALU
  always_comb begin
    if (w_gnt) begin
      w_src1 = req1_src1;
      w_src2 = req1_src2;
      w_fn   = req1_fn;
    end else begin
      w_src1 = req0_src1;
      w_src2 = req0_src2;
      w_fn   = req0_fn;
    end
  end

  alu_arb_alu u_alu (
    .i_src1   (w_src1),
    .i_src2   (w_src2),
    .i_fn     (w_fn),
    .o_result (w_alu_result)
  );

  // Output-slot FSM; a drain and a new accept in one cycle keeps the slot FULL
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= OUT_EMPTY;
      r_owner      <= 1'b0;
      r_result     <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
`ifdef ALU_ARB_RR_EN
      r_prio       <= 1'b0;
`endif
    end else begin
      case (r_state)
        OUT_EMPTY, OUT_FULL: begin
          if (w_accept) begin
            r_state      <= OUT_FULL;
            r_owner      <= w_gnt;
            r_result     <= w_alu_result;
            r_rsp0_valid <= !w_gnt;
            r_rsp1_valid <= w_gnt;
`ifdef ALU_ARB_RR_EN
            r_prio       <= !w_gnt;
`endif
          end else if ((r_state == OUT_FULL) && w_own_ready) begin
            r_state      <= OUT_EMPTY;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
          end else begin
            r_state      <= r_state;
          end
        end
        default: begin
          r_state      <= OUT_EMPTY;
          r_rsp0_valid <= 1'b0;
          r_rsp1_valid <= 1'b0;
        end
      endcase
    end
  end

  assign rsp0_valid  = r_rsp0_valid;
  assign rsp1_valid  = r_rsp1_valid;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;

endmodule

// File: tb/tb_alu_arb.sv
// Self-checking bench for alu_arb: table-driven ALU vectors, a scoreboard of accepted
// results, and directed sequences for arbitration, back-pressure and reset.
import alu_pkg::*;

module tb_alu_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [5:0]  req0_fn, req1_fn;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_exp0, cur_exp1;

  typedef struct {
    logic [5:0]  fn;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic        own;
    logic [31:0] res;
  } ent_t;

  vec_t tbl[15];
  ent_t sbq[$];
  int   glog[$];
  logic m_ptr = 1'b0;
  logic m_after_rst = 1'b1;

  alu_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_src1   (req0_src1),
    .req0_src2   (req0_src2),
    .req0_fn     (req0_fn),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_src1   (req1_src1),
    .req1_src2   (req1_src2),
    .req1_fn     (req1_fn),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Hold the current request until the DUT raises the matching ready (bounded)
  task automatic wait_acc(input logic n);
    int k;
    k = 0;
    @(negedge clk);
    while (!(n ? req1_ready : req0_ready) && k < 8) begin
      @(negedge clk);
      k++;
    end
    if (k >= 8) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout requester %0d: got no ready expected ready within 8 cycles", n);
    end
    cyc();
  endtask

  // Scoreboard: predict readies, check the slot against queued results, then advance
  always @(negedge clk) begin
    logic own_rdy, slot, acc, gnt;
    own_rdy = (sbq.size() > 0) ? (sbq[0].own ? rsp1_ready : rsp0_ready) : 1'b0;
    slot    = (sbq.size() == 0) || own_rdy;
    acc     = rst_n && slot && (req0_valid || req1_valid);
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      gnt = m_ptr;
`else
      gnt = 1'b0;
`endif
    end else begin
      gnt = req1_valid;
    end
    chk1("req0_ready", req0_ready, acc && !gnt);
    chk1("req1_ready", req1_ready, acc && gnt);
    chk1("rsp0_valid", rsp0_valid, (sbq.size() > 0) && !sbq[0].own);
    chk1("rsp1_valid", rsp1_valid, (sbq.size() > 0) && sbq[0].own);
    if (sbq.size() > 0) begin
      chk32("rsp0_result", rsp0_result, sbq[0].res);
      chk32("rsp1_result", rsp1_result, sbq[0].res);
    end else if (m_after_rst) begin
      chk32("rsp0_result_reset", rsp0_result, 32'd0);
      chk32("rsp1_result_reset", rsp1_result, 32'd0);
    end
    if (!rst_n) begin
      sbq.delete();
      m_ptr       = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      if (req0_ready) glog.push_back(0);
      if (req1_ready) glog.push_back(1);
      if ((sbq.size() > 0) && own_rdy) void'(sbq.pop_front());
      if (acc) begin
        sbq.push_back('{own: gnt, res: (gnt ? cur_exp1 : cur_exp0)});
        m_ptr       = !gnt;
        m_after_rst = 1'b0;
      end
    end
  end

  initial begin
    int exp_g[4];
    tbl[0]  = '{6'b010000, 32'd5, 32'd7, 32'd12};
    tbl[1]  = '{6'b000000, 32'h0000DEAD, 32'h0000BEEF, 32'd0};
    tbl[2]  = '{6'b001111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0};
    tbl[3]  = '{6'b010000, 32'hFFFFFFFF, 32'd1, 32'd0};
    tbl[4]  = '{6'b010001, 32'd0, 32'd1, 32'hFFFFFFFF};
    tbl[5]  = '{{FN_CLS_BOOL, BOOL_AND}, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    tbl[6]  = '{{FN_CLS_BOOL, BOOL_OR}, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0};
    tbl[7]  = '{{FN_CLS_BOOL, BOOL_XOR}, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
    tbl[8]  = '{{FN_CLS_BOOL, BOOL_NOR}, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F};
    tbl[9]  = '{{FN_CLS_BOOL, BOOL_SRC1}, 32'h12345678, 32'h0, 32'h12345678};
    tbl[10] = '{6'b110001, 32'h80000000, 32'h0000001F, 32'h00000001};
    tbl[11] = '{6'b110010, 32'h80000000, 32'h00000004, 32'hF8000000};
    tbl[12] = '{6'b110011, 32'h80000001, 32'h00000021, 32'h00000003};
    tbl[13] = '{6'b110000, 32'h00000001, 32'h00000024, 32'h00000010};
    tbl[14] = '{6'b010011, 32'd10, 32'd3, 32'd7};
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif

    // Reset with a pending request: ready must stay low while rst_n=0
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_src1 = 32'd1; req0_src2 = 32'd1; req0_fn = 6'b010000;
    req1_valid = 1'b0; req1_src1 = 32'd0; req1_src2 = 32'd0; req1_fn = 6'b000000;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    cur_exp0 = 32'd0; cur_exp1 = 32'd0;
    repeat (3) cyc();
    rst_n = 1'b1;
    req0_valid = 1'b0;
    @(negedge clk);
    chk1("post_reset_rsp0_valid", rsp0_valid, 1'b0);
    chk32("post_reset_result", rsp0_result, 32'd0);
    chk1("post_reset_req0_ready", req0_ready, 1'b0);
    cyc();

    // ALU vectors through requester 0, back-to-back
    rsp0_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      req0_valid = 1'b1;
      req0_fn    = tbl[i].fn;
      req0_src1  = tbl[i].s1;
      req0_src2  = tbl[i].s2;
      cur_exp0   = tbl[i].exp;
      wait_acc(1'b0);
    end
    req0_valid = 1'b0;
    repeat (2) cyc();

    // Requester 1: subtract wrap and shift with don't-care fn[3:2]
    rsp1_ready = 1'b1;
    req1_valid = 1'b1; req1_fn = 6'b010001; req1_src1 = 32'd3; req1_src2 = 32'd5;
    cur_exp1 = 32'hFFFFFFFE;
    wait_acc(1'b1);
    req1_fn = 6'b111100; req1_src1 = 32'd1; req1_src2 = 32'h24;
    cur_exp1 = 32'h10;
    wait_acc(1'b1);
    req1_valid = 1'b0;
    repeat (2) cyc();

    // Both requesters valid every cycle with both consumers ready
    glog.delete();
    req0_valid = 1'b1; req0_fn = 6'b010000; req0_src1 = 32'd1; req0_src2 = 32'd1; cur_exp0 = 32'd2;
    req1_valid = 1'b1; req1_fn = 6'b010000; req1_src1 = 32'd2; req1_src2 = 32'd2; cur_exp1 = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    repeat (4) cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (2) cyc();
    chk32("grant_count", 32'(glog.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < glog.size()) chk32("grant_order", 32'(glog[i]), 32'(exp_g[i]));
    end

    // Back-pressure: owner 0 stalls 3 cycles while a non-owner ready is asserted
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_fn = 6'b010000; req0_src1 = 32'd10; req0_src2 = 32'd20; cur_exp0 = 32'd30;
    wait_acc(1'b0);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_fn = 6'b010000; req1_src1 = 32'd100; req1_src2 = 32'd1; cur_exp1 = 32'd101;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("stall_req1_ready", req1_ready, 1'b0);
      chk1("stall_rsp0_valid", rsp0_valid, 1'b1);
      chk1("stall_rsp1_valid", rsp1_valid, 1'b0);
      chk32("stall_result", rsp0_result, 32'd30);
      cyc();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk1("drain_accept_req1_ready", req1_ready, 1'b1);
    cyc();
    req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    @(negedge clk);
    chk1("handover_rsp1_valid", rsp1_valid, 1'b1);
    chk1("handover_rsp0_valid", rsp0_valid, 1'b0);
    chk32("handover_result", rsp1_result, 32'd101);
    cyc();
    rsp1_ready = 1'b1;
    repeat (2) cyc();

    // Reset while FULL: slot dropped and tie goes back to requester 0
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_valid = 1'b1; req0_fn = 6'b010000; req0_src1 = 32'd1; req0_src2 = 32'd2; cur_exp0 = 32'd3;
    wait_acc(1'b0);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_full_rsp0_valid", rsp0_valid, 1'b0);
    chk32("rst_full_result", rsp0_result, 32'd0);
    cyc();
    req0_valid = 1'b1; req0_fn = 6'b010000; req0_src1 = 32'd1; req0_src2 = 32'd1; cur_exp0 = 32'd2;
    req1_valid = 1'b1; req1_fn = 6'b010000; req1_src1 = 32'd2; req1_src2 = 32'd2; cur_exp1 = 32'd4;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk1("rst_tie_req0_ready", req0_ready, 1'b1);
    chk1("rst_tie_req1_ready", req1_ready, 1'b0);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
